regfile_mp_sb: RTL and testbench

Parametrised multi-port register file for the next datapath generation: N read ports, M write ports, an optional hard-wired zero register, and a per-register busy scoreboard.
- Long-latency producers (loads, multiply) reserve a destination register. The entry stays busy until the result is written back.
- Decode logic stalls on busy source operands.
- Replaces the single-write, two-read file in the pipeline register stage.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_scoreboard.sv | 87 ++++++++
 rtl/regfile_mp_sb.sv | 124 ++++++++++++
 tb/tb_regfile_mp_sb.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, register typedefs and the busy-vector population count for regfile_mp_sb.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH    = 64;
  localparam int DEF_ADDRESS_WIDTH = 5;
  localparam int MAX_ADDRESS_WIDTH = 8;
  localparam int MAX_DEPTH         = 256;
  localparam int CNT_WIDTH         = 9;

  typedef logic [DEF_ADDRESS_WIDTH-1:0] reg_addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0]    reg_data_t;

  // Counts set bits of a busy vector zero-extended to MAX_DEPTH entries.
  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [MAX_DEPTH-1:0] vec);
    logic [CNT_WIDTH-1:0] cnt;
    cnt = {CNT_WIDTH{1'b0}};
    for (int i = 0; i < MAX_DEPTH; i++) begin
      cnt = cnt + {{(CNT_WIDTH-1){1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reservation accept, set-over-clear priority, busy count.
// Honours REGFILE_BYPASS_EN: a same-cycle writeback hides the busy bit on read ports.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int NUM_READ      = 3,
  parameter int ZERO_REG      = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [(1<<ADDRESS_WIDTH)-1:0]     clr_vec,
  input  logic                              rsv_valid,
  input  logic [ADDRESS_WIDTH-1:0]          rsv_addr,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0] ra,
  output logic                              rsv_ready,
  output logic [NUM_READ-1:0]               rd_busy,
  output logic [ADDRESS_WIDTH:0]            busy_count
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [DEPTH-1:0]         busy_r;
  logic [DEPTH-1:0]         busy_nxt_s;
  logic [DEPTH-1:0]         set_vec_s;
  logic [MAX_DEPTH-1:0]     busy_ext_s;
  logic [CNT_WIDTH-1:0]     pop_s;
  logic [ADDRESS_WIDTH:0]   busy_count_r;
  logic                     rsv_ready_s;
  logic [NUM_READ-1:0]      rd_busy_s;

  // Reservation accept: free register, or one being written back this cycle.
  always_comb begin
    rsv_ready_s = (~busy_r[rsv_addr]) | clr_vec[rsv_addr];
  end

  // Next busy vector; a granted reservation beats a same-cycle clear.
  always_comb begin
    set_vec_s = '0;
    if (rsv_valid && rsv_ready_s && !(ZERO_EN && (rsv_addr == '0))) begin
      set_vec_s[rsv_addr] = 1'b1;
    end else begin
      set_vec_s = '0;
    end
    busy_nxt_s = (busy_r & ~clr_vec) | set_vec_s;
    busy_ext_s = '0;
    busy_ext_s[DEPTH-1:0] = busy_nxt_s;
    pop_s = popcount(busy_ext_s);
  end

  // Busy vector and its registered population count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r       <= '0;
      busy_count_r <= '0;
    end else begin
      busy_r       <= busy_nxt_s;
      busy_count_r <= pop_s[ADDRESS_WIDTH:0];
    end
  end

  // Per-read-port busy lookup; the zero register never reports busy.
  always_comb begin
    rd_busy_s = '0;
    for (int r = 0; r < NUM_READ; r++) begin
      logic [ADDRESS_WIDTH-1:0] addr_v;
      logic                     bit_v;
      addr_v = ra[r*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      bit_v  = busy_r[addr_v];
`ifdef REGFILE_BYPASS_EN
      bit_v  = bit_v & ~clr_vec[addr_v];
`endif
      if (ZERO_EN && (addr_v == '0)) begin
        bit_v = 1'b0;
      end else begin
        bit_v = bit_v;
      end
      rd_busy_s[r] = bit_v;
    end
  end

  assign rsv_ready  = rsv_ready_s;
  assign rd_busy    = rd_busy_s;
  assign busy_count = busy_count_r;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with optional zero register and busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to read ports.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int NUM_READ      = 3,
  parameter int NUM_WRITE     = 2,
  parameter int ZERO_REG      = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_WRITE-1:0]              we,
  input  logic [NUM_WRITE*ADDRESS_WIDTH-1:0] wa,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]   wd,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0] ra,
  output logic [NUM_READ*DATA_WIDTH-1:0]    rd,
  output logic [NUM_READ-1:0]               rd_busy,
  input  logic                              rsv_valid,
  input  logic [ADDRESS_WIDTH-1:0]          rsv_addr,
  output logic                              rsv_ready,
  output logic [ADDRESS_WIDTH:0]            busy_count
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  generate
    if (DATA_WIDTH < 1) begin : g_bad_dw
      $error("regfile_mp_sb: DATA_WIDTH must be at least 1");
    end
    if ((ADDRESS_WIDTH < 1) || (ADDRESS_WIDTH > MAX_ADDRESS_WIDTH)) begin : g_bad_aw
      $error("regfile_mp_sb: ADDRESS_WIDTH out of range 1..8");
    end
    if ((NUM_READ < 1) || (NUM_READ > 4)) begin : g_bad_nr
      $error("regfile_mp_sb: NUM_READ out of range 1..4");
    end
    if ((NUM_WRITE < 1) || (NUM_WRITE > 2)) begin : g_bad_nw
      $error("regfile_mp_sb: NUM_WRITE out of range 1..2");
    end
    if ((ZERO_REG < 0) || (ZERO_REG > 1)) begin : g_bad_zr
      $error("regfile_mp_sb: ZERO_REG must be 0 or 1");
    end
  endgenerate

  logic [DATA_WIDTH-1:0]          mem_r [DEPTH];
  logic [DEPTH-1:0]               clr_vec_s;
  logic [NUM_READ*DATA_WIDTH-1:0] rd_s;

  // Registers actually written this cycle; drives both data update and busy clear.
  always_comb begin
    clr_vec_s = '0;
    for (int p = 0; p < NUM_WRITE; p++) begin
      logic [ADDRESS_WIDTH-1:0] waddr_v;
      waddr_v = wa[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      if (we[p] && !(ZERO_EN && (waddr_v == '0))) begin
        clr_vec_s[waddr_v] = 1'b1;
      end else begin
        clr_vec_s = clr_vec_s;
      end
    end
  end

  // Data array; later loop iterations override, so the higher port wins a conflict.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_WRITE; p++) begin
        if (we[p] && !(ZERO_EN && (wa[p*ADDRESS_WIDTH +: ADDRESS_WIDTH] == '0))) begin
          mem_r[wa[p*ADDRESS_WIDTH +: ADDRESS_WIDTH]] <= wd[p*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Read ports: array contents, optional forwarding, zero register last.
  always_comb begin
    rd_s = '0;
    for (int r = 0; r < NUM_READ; r++) begin
      logic [ADDRESS_WIDTH-1:0] raddr_v;
      logic [DATA_WIDTH-1:0]    data_v;
      raddr_v = ra[r*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      data_v  = mem_r[raddr_v];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < NUM_WRITE; p++) begin
        if (we[p] && (wa[p*ADDRESS_WIDTH +: ADDRESS_WIDTH] == raddr_v)) begin
          data_v = wd[p*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          data_v = data_v;
        end
      end
`endif
      if (ZERO_EN && (raddr_v == '0)) begin
        data_v = '0;
      end else begin
        data_v = data_v;
      end
      rd_s[r*DATA_WIDTH +: DATA_WIDTH] = data_v;
    end
  end

  assign rd = rd_s;

  regfile_scoreboard #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .NUM_READ      (NUM_READ),
    .ZERO_REG      (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .clr_vec    (clr_vec_s),
    .rsv_valid  (rsv_valid),
    .rsv_addr   (rsv_addr),
    .ra         (ra),
    .rsv_ready  (rsv_ready),
    .rd_busy    (rd_busy),
    .busy_count (busy_count)
  );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed self-checking bench for regfile_mp_sb (default parameters).
// Expectations follow REGFILE_BYPASS_EN when the macro is defined for the build.
module tb_regfile_mp_sb;
  import regfile_pkg::*;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 3;
  localparam int NW = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [NW-1:0]     we;
  logic [NW*AW-1:0]  wa;
  logic [NW*DW-1:0]  wd;
  logic [NR*AW-1:0]  ra;
  logic [NR*DW-1:0]  rd;
  logic [NR-1:0]     rd_busy;
  logic              rsv_valid;
  reg_addr_t         rsv_addr;
  logic              rsv_ready;
  logic [AW:0]       busy_count;

  int tests_run;
  int tests_failed;

  regfile_mp_sb #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_READ(NR), .NUM_WRITE(NW), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd),
    .rd_busy(rd_busy), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .rsv_ready(rsv_ready), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    we = '0;
    rsv_valid = 1'b0;
  endtask

  task automatic set_wr(input int p, input reg_addr_t a, input reg_data_t d);
    we[p] = 1'b1;
    wa[p*AW +: AW] = a;
    wd[p*DW +: DW] = d;
  endtask

  task automatic set_ra(input int r, input reg_addr_t a);
    ra[r*AW +: AW] = a;
  endtask

  function automatic reg_data_t rd_of(input int r);
    return rd[r*DW +: DW];
  endfunction

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    tests_run = 0;
    tests_failed = 0;
    we = '0; wa = '0; wd = '0; ra = '0;
    rsv_valid = 1'b0; rsv_addr = '0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_val("reset_count", 64'(busy_count), 64'd0);
    check_val("reset_ready", 64'(rsv_ready), 64'd1);

    // Populate some state, then pulse reset over it
    rst = 1'b1;
    set_wr(0, 5'd4, 64'hDEAD); set_wr(1, 5'd6, 64'hBEEF);
    rsv_valid = 1'b1; rsv_addr = 5'd2;
    @(negedge clk); idle();
    set_ra(0, 5'd4); set_ra(1, 5'd6); set_ra(2, 5'd2); #1;
    check_val("pre_rd0", rd_of(0), 64'hDEAD);
    check_val("pre_rd1", rd_of(1), 64'hBEEF);
    check_val("pre_busy2", 64'(rd_busy[2]), 64'd1);
    check_val("pre_count", 64'(busy_count), 64'd1);
    rst = 1'b0; #1;
    check_val("rst_rd0", rd_of(0), 64'd0);
    check_val("rst_rd1", rd_of(1), 64'd0);
    check_val("rst_busy2", 64'(rd_busy[2]), 64'd0);
    check_val("rst_count", 64'(busy_count), 64'd0);
    check_val("rst_ready", 64'(rsv_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1; #1;
    check_val("post_rst_rd0", rd_of(0), 64'd0);

    // Write-write conflict on r7
    set_wr(0, 5'd7, 64'hAAAA); set_wr(1, 5'd7, 64'h5555); set_ra(0, 5'd7); #1;
    check_val("conflict_same_cyc", rd_of(0), BYP ? 64'h5555 : 64'd0);
    @(negedge clk); idle(); #1;
    check_val("conflict_r7", rd_of(0), 64'h5555);

    // Zero register
    set_wr(0, 5'd0, 64'hFFFF); rsv_valid = 1'b1; rsv_addr = 5'd0; set_ra(0, 5'd0); #1;
    check_val("zero_ready", 64'(rsv_ready), 64'd1);
    check_val("zero_rd_same", rd_of(0), 64'd0);
    @(negedge clk); idle(); #1;
    check_val("zero_rd", rd_of(0), 64'd0);
    check_val("zero_busy", 64'(rd_busy[0]), 64'd0);
    check_val("zero_count", 64'(busy_count), 64'd0);

    // Scoreboard stall on r5
    rsv_valid = 1'b1; rsv_addr = 5'd5; set_ra(0, 5'd5); #1;
    check_val("r5_ready_first", 64'(rsv_ready), 64'd1);
    check_val("r5_busy_before", 64'(rd_busy[0]), 64'd0);
    @(negedge clk); #1;
    check_val("r5_ready_second", 64'(rsv_ready), 64'd0);
    check_val("r5_busy", 64'(rd_busy[0]), 64'd1);
    check_val("r5_count", 64'(busy_count), 64'd1);
    @(negedge clk); rsv_valid = 1'b0; #1;
    check_val("r5_count_hold", 64'(busy_count), 64'd1);
    set_wr(1, 5'd5, 64'h77); #1;
    check_val("r5_ready_wb", 64'(rsv_ready), 64'd1);
    check_val("r5_busy_wb", 64'(rd_busy[0]), BYP ? 64'd0 : 64'd1);
    @(negedge clk); idle(); #1;
    check_val("r5_busy_clr", 64'(rd_busy[0]), 64'd0);
    check_val("r5_count_clr", 64'(busy_count), 64'd0);
    check_val("r5_data", rd_of(0), 64'h77);

    // Set dominates clear on r9
    rsv_valid = 1'b1; rsv_addr = 5'd9; set_wr(0, 5'd9, 64'h9999); set_ra(0, 5'd9); #1;
    check_val("r9_ready", 64'(rsv_ready), 64'd1);
    @(negedge clk); idle(); #1;
    check_val("r9_data", rd_of(0), 64'h9999);
    check_val("r9_busy", 64'(rd_busy[0]), 64'd1);
    check_val("r9_count", 64'(busy_count), 64'd1);
    set_wr(0, 5'd9, 64'h1);
    @(negedge clk); idle(); #1;
    check_val("r9_count_clr", 64'(busy_count), 64'd0);
    check_val("r9_data2", rd_of(0), 64'h1);

    // Read-during-write on r3
    set_wr(1, 5'd3, 64'h1234); set_ra(2, 5'd3); #1;
    check_val("r3_same_cyc", rd_of(2), BYP ? 64'h1234 : 64'd0);
    @(negedge clk); idle(); #1;
    check_val("r3_next", rd_of(2), 64'h1234);

    // Several reservations, partial writeback, then reset mid-operation
    rsv_valid = 1'b1; rsv_addr = 5'd10;
    @(negedge clk); rsv_addr = 5'd11;
    @(negedge clk); rsv_addr = 5'd12;
    @(negedge clk); rsv_valid = 1'b0;
    set_ra(0, 5'd10); set_ra(1, 5'd11); set_ra(2, 5'd12); #1;
    check_val("multi_count3", 64'(busy_count), 64'd3);
    check_val("multi_busy3", 64'(rd_busy), 64'b111);
    set_wr(0, 5'd10, 64'hA); set_wr(1, 5'd11, 64'hB);
    rsv_valid = 1'b1; rsv_addr = 5'd13;
    @(negedge clk); idle(); set_ra(2, 5'd13); #1;
    check_val("multi_count2", 64'(busy_count), 64'd2);
    check_val("multi_busy2", 64'(rd_busy), 64'b100);
    rst = 1'b0; #1;
    check_val("mid_rst_count", 64'(busy_count), 64'd0);
    check_val("mid_rst_busy", 64'(rd_busy), 64'd0);
    set_ra(0, 5'd9); #1;
    check_val("mid_rst_rd", rd_of(0), 64'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
